// File: rtl/led_activity_array.sv
// Per-channel activity LED stretcher: each qualified pulse holds the LED lit for HOLD_CLK+1 cycles.
// Optional blink overlay compiled in with `define LED_BLINK_EN.
module led_activity_array #(
  parameter int CHANNELS   = 4,
  parameter int HOLD_CLK   = 10000,
  parameter int CNT_W      = 32,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_CLK  = 2500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] activity,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CLK);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [CHANNELS-1:0] busy_d;
  logic [CHANNELS-1:0] blink_mask;
  logic [CHANNELS-1:0] lit_q;
  logic [CHANNELS-1:0] lit_d;

`ifdef LED_BLINK_EN
  localparam int               PRE_W   = (BLINK_CLK > 1) ? $clog2(BLINK_CLK) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BLINK_CLK - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             phase_q;
  logic             phase_d;

  always_comb begin
    pre_d   = pre_q + 1'b1;
    phase_d = phase_q;
    if (pre_q == PRE_MAX) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  // Next-cycle phase keeps the registered LED aligned with busy.
  assign blink_mask = ~mode | {CHANNELS{phase_d}};
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign blink_mask  = '1;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse;

    assign pulse = activity[gi] & en[gi];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (pulse) begin
            state_d = HOLD;
            cnt_d   = HOLD_VAL;
          end
        end
        HOLD: begin
          if (pulse) begin
            cnt_d = HOLD_VAL;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign busy[gi]   = (state_q == HOLD);
    assign busy_d[gi] = (state_d == HOLD);
  end

  assign lit_d = busy_d & blink_mask;

  // Storing "lit" rather than the pin level lets every register reset and power up at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      lit_q <= '0;
    end else begin
      lit_q <= lit_d;
    end
  end

  assign led = lit_q ^ {CHANNELS{POL}};

endmodule

// File: tb/tb_led_activity_array.sv
// Directed-vector scoreboard bench for led_activity_array (HOLD_CLK=5 and HOLD_CLK=0 instances).
module tb_led_activity_array;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] activity = '0;
  logic [3:0] en = '0;
  logic [3:0] mode = '0;
  logic [3:0] led;
  logic [3:0] busy;
  logic [3:0] led0;
  logic [3:0] busy0;
  logic [3:0] mode0 = '0;

  always #5 clk = ~clk;

  led_activity_array #(
    .CHANNELS(4), .HOLD_CLK(5), .CNT_W(8), .ACTIVE_LOW(1), .BLINK_CLK(3)
  ) u_dut (
    .clk(clk), .reset(reset), .activity(activity), .en(en), .mode(mode),
    .led(led), .busy(busy)
  );

  led_activity_array #(
    .CHANNELS(4), .HOLD_CLK(0), .CNT_W(8), .ACTIVE_LOW(1), .BLINK_CLK(3)
  ) u_dut0 (
    .clk(clk), .reset(reset), .activity(activity), .en(en), .mode(mode0),
    .led(led0), .busy(busy0)
  );

  typedef struct packed {
    logic [3:0] busy;
    logic [3:0] led;
    logic [3:0] busy0;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   vec_id = 0;

  // Apply one vector n times; expected values describe the cycle after each edge.
  task automatic vec(input logic r, input logic [3:0] a, input logic [3:0] e,
                     input logic [3:0] m, input logic [3:0] b, input logic [3:0] l,
                     input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset    = r;
      activity = a;
      en       = e;
      mode     = m;
      x.busy   = b;
      x.led    = l;
      x.busy0  = r ? 4'b0000 : (a & e);
      x.idx    = vec_id;
      sb.push_back(x);
      vec_id++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (busy !== e.busy || led !== e.led || busy0 !== e.busy0 || led0 !== ~e.busy0) begin
          n_bad++;
          $display("FAIL vec%0d: busy=%b want %b led=%b want %b hold0_busy=%b want %b hold0_led=%b want %b",
                   e.idx, busy, e.busy, led, e.led, busy0, e.busy0, led0, ~e.busy0);
        end else begin
          $display("vec%0d ok: busy=%b led=%b hold0_busy=%b", e.idx, busy, led, busy0);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset state, reset priority over activity
    vec(1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    vec(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    // Single pulse on ch0: lit 6 cycles, then dark
    vec(1'b0, 4'h1, 4'hF, 4'h0, 4'h1, 4'hE, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h1, 4'hE, 5);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    // ch1 pulses 4 cycles apart: reload extends hold
    vec(1'b0, 4'h2, 4'hF, 4'h0, 4'h2, 4'hD, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h2, 4'hD, 3);
    vec(1'b0, 4'h2, 4'hF, 4'h0, 4'h2, 4'hD, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h2, 4'hD, 5);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    // en masks ch2; dropping en mid-hold does not cancel it
    vec(1'b0, 4'hF, 4'hB, 4'h0, 4'hB, 4'h4, 1);
    vec(1'b0, 4'hF, 4'h0, 4'h0, 4'hB, 4'h4, 5);
    vec(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1);
    // Reset mid-hold on ch3 aborts at once, coincident pulse ignored
    vec(1'b0, 4'h8, 4'hF, 4'h0, 4'h8, 4'h7, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h8, 4'h7, 2);
    vec(1'b1, 4'h8, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    // Continuous activity on ch0+ch2 keeps them lit
    vec(1'b0, 4'h5, 4'hF, 4'h0, 4'h5, 4'hA, 8);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h5, 4'hA, 5);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
    // Pulses 2 cycles apart (HOLD_CLK=0 instance lights exactly those cycles)
    vec(1'b0, 4'h1, 4'hF, 4'h0, 4'h1, 4'hE, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h1, 4'hE, 1);
    vec(1'b0, 4'h1, 4'hF, 4'h0, 4'h1, 4'hE, 1);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h1, 4'hE, 5);
    vec(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1);
`ifdef LED_BLINK_EN
    begin : blink
      logic [11:0] lit_pat;
      lit_pat = 12'b0111_0001_1100; // index 0 is the first vector after reset
      vec(1'b1, 4'h0, 4'hF, 4'h1, 4'h0, 4'hF, 1);
      for (int k = 0; k < 12; k++) begin
        vec(1'b0, 4'h1, 4'hF, 4'h1, 4'h1, {3'b111, ~lit_pat[k]}, 1);
      end
    end
`endif
    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/led_activity_array.md
LED_ACTIVITY_ARRAY -- requirements
Module: led_activity_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent activity channels, range 1..32.
REQ-002 Parameter HOLD_CLK, default 10000: minimum on-time in clk cycles after the last activity pulse.
REQ-003 Parameter CNT_W, default 32: hold counter width; HOLD_CLK SHALL fit in CNT_W bits.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means a lit LED drives 0, and 0 means a lit LED drives 1.
REQ-005 Parameter BLINK_CLK, default 2500000: blink half-period in clk cycles; used only with LED_BLINK_EN.
REQ-006 clk  input  1  sole clock; all logic is on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 activity  input  CHANNELS  per-channel activity strobe, synchronous to clk, level-sampled every cycle.
REQ-009 en  input  CHANNELS  per-channel enable; when low, activity on that channel is ignored.
REQ-010 mode  input  CHANNELS  per-channel blink select; present in every build, functional only with LED_BLINK_EN.
REQ-011 led  output  CHANNELS  LED drive, registered, polarity per ACTIVE_LOW.
REQ-012 busy  output  CHANNELS  active-high: the channel is in state HOLD.

Function
REQ-013 Each channel SHALL have a 2-state FSM: IDLE and HOLD.
REQ-014 The channel SHALL have a CNT_W-bit hold counter.
REQ-015 A qualified pulse is activity[i] & en[i].
REQ-016 IDLE with a qualified pulse SHALL go to HOLD and load counter = HOLD_CLK.
REQ-017 HOLD with a qualified pulse SHALL stay in HOLD and reload counter = HOLD_CLK.
  - A reload has priority over the decrement and over the expiry check.
REQ-018 HOLD without a pulse:
  - counter == 0: go to IDLE.
  - otherwise: decrement by 1.
  - The counter never wraps below 0.
REQ-019 Latency: a qualified pulse at cycle n SHALL light led[i] and set busy[i] at cycle n+1.
REQ-020 After the last qualified pulse at cycle n, the LED SHALL stay lit exactly HOLD_CLK+1 cycles (n+1..n+1+HOLD_CLK) and go dark at n+2+HOLD_CLK.
REQ-021 HOLD_CLK = 0 SHALL give exactly one lit cycle per isolated pulse.
REQ-022 Continuous activity SHALL keep the LED lit indefinitely.
REQ-023 Dropping en[i] while in HOLD SHALL NOT cancel the hold; the channel expires normally.
REQ-024 Channels SHALL be fully independent; simultaneous pulses on any subset are each handled in the same cycle.
REQ-025 led[i] = lit XOR ACTIVE_LOW, where lit = busy[i] (non-blink case).

Reset
REQ-026 With reset high at a rising edge, the following SHALL apply on the next cycle:
  - all channels IDLE, counters 0, busy = 0;
  - led = all-ones if ACTIVE_LOW = 1, else all-zeros;
  - blink prescaler 0 and blink phase 0.
REQ-027 Reset SHALL take priority over activity in the same cycle.
REQ-028 Reset mid-hold SHALL abort the hold immediately.
REQ-029 Out of reset, all registers SHALL also power up at the REQ-026 values.

Configuration
REQ-030 The macro LED_BLINK_EN SHALL compile in the blink feature:
  - adds a free-running prescaler counting 0..BLINK_CLK-1;
  - the shared phase bit toggles on each wrap;
  - with mode[i]=1, lit = busy[i] & phase; with mode[i]=0, lit = busy[i].
REQ-031 Without LED_BLINK_EN:
  - no prescaler or phase logic is synthesised;
  - mode is ignored;
  - lit = busy[i] for every channel.
REQ-032 busy SHALL be unaffected by blinking in both builds.

Verification (CHANNELS=4, HOLD_CLK=5, ACTIVE_LOW=1, BLINK_CLK=3 unless noted)
REQ-033 Single pulse on ch0 at cycle 10, en=4'hF -> led[0]=0 for cycles 11..16, led[0]=1 at 17; busy[0] mirrors this; other channels stay at led=1.
REQ-034 Pulses on ch1 at cycles 10 and 14 -> led[1] lit for cycles 11..20, dark at 21 (reload extends the hold).
REQ-035 en=4'b1011, pulses on all channels at cycle 5 -> led = 4'b0100 at cycle 6; ch2 never lit.
REQ-036 Pulse on ch3 at cycle 10, reset high at cycle 13 -> led[3]=1 and busy[3]=0 at cycle 14; a pulse at cycle 13 with reset high has no effect.
REQ-037 LED_BLINK_EN defined, mode=4'b0001, activity[0] held high from cycle 0 -> busy[0]=1 constant; led[0] alternates 3 cycles lit / 3 cycles dark.
REQ-038 HOLD_CLK=0, pulses on ch0 at cycles 4 and 6 -> led[0] lit only at cycles 5 and 7.
